// File: rtl/uart_tx.sv
// 8N1 serial transmitter: one byte per accepted request, LSB first, fixed bit period.
// All outputs are registered so the pin never glitches.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntTerm = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [2:0]      r_idx, w_idx_d;
    logic [7:0]      r_shift, w_shift_d;
    logic            r_tx, w_tx_d;
    logic            r_busy, w_busy_d;
    logic            r_done, w_done_d;
    logic            w_term;

    assign w_term = (r_cnt == CntTerm);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_idx_d   = r_idx;
        w_shift_d = r_shift;
        w_done_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_tx_start) begin
                    w_shift_d = i_tx_data;
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (w_term) begin
                    w_cnt_d   = '0;
                    w_state_d = StData;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StData: begin
                if (w_term) begin
                    w_cnt_d   = '0;
                    w_shift_d = r_shift >> 1;
                    if (r_idx == 3'd7) begin
                        w_state_d = StStop;
                    end else begin
                        w_idx_d = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StStop: begin
                if (w_term) begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Line level is derived from the state being entered so it lands on the same edge.
        case (w_state_d)
            StStart: w_tx_d = 1'b0;
            StData:  w_tx_d = w_shift_d[0];
            default: w_tx_d = 1'b1;
        endcase
        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            r_shift <= w_shift_d;
            r_tx    <= w_tx_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
        end
    end

    assign o_tx      = r_tx;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART path: takes one parallel byte per request and shifts it out as an 8N1 frame (start bit, 8 data bits LSB first, one stop bit) at a fixed bit period derived from the system clock by an internal divider counter. It sits between the byte-producing logic (loopback/command logic) and the FPGA TX pin. It is the transmit-side counterpart of the receiver and display path already in the design.

## Interface

- CLKS_PER_BIT, 5208, system clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..2^16-1
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tx_start  input  1  transmit request; sampled only in IDLE
- tx_data  input  8  byte to send; captured on the accepted tx_start cycle
- tx  output  1  serial line, idle high
- tx_busy  output  1  high from accepted request until frame end
- tx_done  output  1  one-cycle pulse at frame completion

## Operation

- States: IDLE, START, DATA, STOP. Single bit-period counter (width ceil(log2(CLKS_PER_BIT))), 3-bit bit index, 8-bit shift register.
- IDLE: tx=1, tx_busy=0. On tx_start=1 at an edge: latch tx_data, clear counter and bit index, go START, tx_busy=1.
- START: tx=0. Counter counts 0..CLKS_PER_BIT-1; at terminal count clear counter, go DATA.
- DATA: tx=shift_reg[0]. At terminal count clear counter and shift right by one; if bit index=7 go STOP, else increment index.
- STOP: tx=1. At terminal count go IDLE, pulse tx_done for one cycle.
- tx_start while tx_busy=1 is ignored (not queued). tx_data changes after capture have no effect on the frame in flight.
- tx is a registered output (no glitches on the pin).
- Reset: state IDLE, tx=1, tx_busy=0, tx_done=0, counter, index and shift register cleared. Reset mid-frame aborts the frame: tx=1 on the cycle after the reset edge, no tx_done pulse.
- rst and tx_start asserted together: reset wins, request is dropped.

## Timing

- Request accepted at edge N: from edge N, tx=0 and tx_busy=1.
- Each bit held exactly CLKS_PER_BIT cycles: start bit edges N..N+CPB, data bit k (k=0..7) edges N+(k+1)·CPB..N+(k+2)·CPB, stop bit edges N+9·CPB..N+10·CPB.
- At edge N+10·CPB: state IDLE, tx_busy=0, tx_done=1 for exactly that one cycle, tx=1.
- Back-to-back: tx_start high during the tx_done cycle is accepted at edge N+10·CPB+1; the resulting gap between stop bit end and next start bit is exactly one clock cycle (line high).
- Throughput: one byte per 10·CPB+1 cycles maximum.
- tx_busy and tx_done are never high in the same cycle.

## Test plan

- Reset: hold rst 3 cycles with tx_start=1, tx_data=8'hFF -> tx=1, tx_busy=0, tx_done=0 throughout and after; no frame started.
- Single frame, CLKS_PER_BIT=4: send 8'hA5 -> tx sequence (4 cycles each) 0,1,0,1,0,0,1,0,1,1; tx_done one cycle exactly 40 cycles after accept edge; tx_busy high for 40 cycles.
- Back-to-back, CPB=4: send 8'h00 then 8'hFF with tx_start held high continuously -> two frames, second start bit begins 41 cycles after first accept; exactly one idle-high cycle between frames; two tx_done pulses.
- Ignore while busy: send 8'h3C, pulse tx_start with tx_data=8'hC3 at cycle 15 and change tx_data mid-frame -> line carries only 8'h3C, one tx_done pulse.
- Reset mid-frame, CPB=4: send 8'h55, assert rst at cycle 18 (data bit 3) -> tx=1 and tx_busy=0 next cycle, no tx_done; subsequent 8'h81 request sends a clean full frame.
- Default parameter: send 8'h41 with CPB=5208 -> each bit width measured 5208 cycles, frame 52080 cycles to tx_done.
